// File: rtl/johnson_dec_if.sv
`default_nettype none
// ============================================================================
// Module   : johnson_dec_if
// Purpose  : Sample and result bus between a Johnson-code source and johnson_dec.
// Revision : 1.0 - initial release
// ============================================================================
interface johnson_dec_if #(
    parameter int N  = 8,
    parameter int CW = 8
);
    localparam int c_W = $clog2(2 * N);

    logic           in_valid;
    logic [N-1:0]   in;
    logic           out_valid;
    logic [c_W-1:0] idx;
    logic           legal;
    logic           fwd;
    logic           bwd;
    logic           hold;
    logic           skip;
    logic           err;
    logic [CW-1:0]  err_cnt;

    modport master (
        output in_valid, in,
        input  out_valid, idx, legal, fwd, bwd, hold, skip, err, err_cnt
    );

    modport slave (
        input  in_valid, in,
        output out_valid, idx, legal, fwd, bwd, hold, skip, err, err_cnt
    );
endinterface
`default_nettype wire

// File: rtl/johnson_dec.sv
`default_nettype none
// ============================================================================
// Module   : johnson_dec
// Purpose  : Johnson-code decoder/checker: index, step class, error tracking.
// Revision : 1.0 - initial release
// ============================================================================
module johnson_dec #(
    parameter int N  = 8,
    parameter int CW = 8
) (
    input  wire logic       clk,
    input  wire logic       clr,
    johnson_dec_if.slave    bus
);
    localparam int             c_W    = $clog2(2 * N);
    localparam logic [N-1:0]   c_ONES = '1;
    localparam logic [c_W-1:0] c_LAST = c_W'(2 * N - 1);

    logic [N-1:0]   r_in;
    logic           r_pend;
    logic [c_W-1:0] r_prev;
    logic           r_primed;
    logic           r_out_valid;
    logic [c_W-1:0] r_idx;
    logic           r_legal;
    logic           r_fwd;
    logic           r_bwd;
    logic           r_hold;
    logic           r_skip;
    logic           r_err;
    logic [CW-1:0]  r_cnt;

    logic           w_legal;
    logic [c_W-1:0] w_idx;
    logic           w_fwd;
    logic           w_bwd;
    logic           w_hold;
    logic           w_stepped;
    logic           w_skip;
    logic           w_event;

    // Low thermometers give m, high thermometers give 2N-m.
    always_comb begin
        w_legal = 1'b0;
        w_idx   = '0;
        for (int m = 0; m <= N; m++) begin
            if (r_in == (c_ONES >> (N - m))) begin
                w_legal = 1'b1;
                w_idx   = c_W'(m);
            end
        end
        for (int m = 1; m < N; m++) begin
            if (r_in == ~(c_ONES >> m)) begin
                w_legal = 1'b1;
                w_idx   = c_W'(2 * N - m);
            end
        end
    end

    // 2N is not always a power of two, so wrap the neighbours explicitly.
    assign w_fwd     = (r_prev == c_LAST) ? (w_idx == '0)     : (w_idx == r_prev + 1'b1);
    assign w_bwd     = (r_prev == '0)     ? (w_idx == c_LAST) : (w_idx == r_prev - 1'b1);
    assign w_hold    = (w_idx == r_prev);
    assign w_stepped = r_pend & w_legal & r_primed;
    assign w_skip    = w_stepped & ~(w_fwd | w_bwd | w_hold);
    assign w_event   = r_pend & (~w_legal | w_skip);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_in        <= '0;
            r_pend      <= 1'b0;
            r_prev      <= '0;
            r_primed    <= 1'b0;
            r_out_valid <= 1'b0;
            r_idx       <= '0;
            r_legal     <= 1'b0;
            r_fwd       <= 1'b0;
            r_bwd       <= 1'b0;
            r_hold      <= 1'b0;
            r_skip      <= 1'b0;
            r_err       <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_pend      <= bus.in_valid;
            if (bus.in_valid) begin
                r_in <= bus.in;
            end
            r_out_valid <= r_pend;
            r_legal     <= r_pend & w_legal;
            r_fwd       <= w_stepped & w_fwd;
            r_bwd       <= w_stepped & w_bwd;
            r_hold      <= w_stepped & w_hold;
            r_skip      <= w_skip;
            // An illegal word leaves idx showing the last legal index (= prev).
            if (r_pend && w_legal) begin
                r_idx    <= w_idx;
                r_prev   <= w_idx;
                r_primed <= 1'b1;
            end
            if (w_event) begin
                r_err <= 1'b1;
                if (r_cnt != '1) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.idx       = r_idx;
    assign bus.legal     = r_legal;
    assign bus.fwd       = r_fwd;
    assign bus.bwd       = r_bwd;
    assign bus.hold      = r_hold;
    assign bus.skip      = r_skip;
    assign bus.err       = r_err;
    assign bus.err_cnt   = r_cnt;
endmodule
`default_nettype wire

// File: tb/tb_johnson_dec.sv
`default_nettype none
// ============================================================================
// Module   : tb_johnson_dec
// Purpose  : Scoreboard bench for johnson_dec (N=3; CW=8 and CW=2 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_johnson_dec;
    typedef struct packed {
        logic [2:0] idx;
        logic       legal;
        logic       fwd;
        logic       bwd;
        logic       hold;
        logic       skip;
        logic       err;
        logic [7:0] cnt;
    } exp_t;

    logic clk   = 1'b0;
    logic clr_a = 1'b0;
    logic clr_b = 1'b0;
    always #5 clk = ~clk;

    johnson_dec_if #(.N(3), .CW(8)) ifa();
    johnson_dec_if #(.N(3), .CW(2)) ifb();

    johnson_dec #(.N(3), .CW(8)) u_a (.clk(clk), .clr(clr_a), .bus(ifa.slave));
    johnson_dec #(.N(3), .CW(2)) u_b (.clk(clk), .clr(clr_b), .bus(ifb.slave));

    int   checks = 0;
    int   errors = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, aa, eb, ab;

    int   m_prev[2];
    bit   m_primed[2];
    bit   m_err[2];
    int   m_cnt[2];
    int   m_max[2] = '{255, 3};

    // Reference model: table decode and modular step distance.
    function automatic exp_t model(int d, logic [2:0] code);
        exp_t e;
        int   i;
        bit   ev;
        case (code)
            3'b000:  i = 0;
            3'b001:  i = 1;
            3'b011:  i = 2;
            3'b111:  i = 3;
            3'b110:  i = 4;
            3'b100:  i = 5;
            default: i = -1;
        endcase
        e  = '0;
        ev = 1'b0;
        if (i < 0) begin
            e.idx = 3'(m_prev[d]);
            ev    = 1'b1;
        end else begin
            e.legal = 1'b1;
            e.idx   = 3'(i);
            if (m_primed[d]) begin
                case ((i - m_prev[d] + 6) % 6)
                    0:       e.hold = 1'b1;
                    1:       e.fwd  = 1'b1;
                    5:       e.bwd  = 1'b1;
                    default: begin e.skip = 1'b1; ev = 1'b1; end
                endcase
            end
            m_prev[d]   = i;
            m_primed[d] = 1'b1;
        end
        if (ev) begin
            m_err[d] = 1'b1;
            if (m_cnt[d] < m_max[d]) m_cnt[d]++;
        end
        e.err = m_err[d];
        e.cnt = 8'(m_cnt[d]);
        return e;
    endfunction

    task automatic model_clear(int d);
        m_prev[d]   = 0;
        m_primed[d] = 1'b0;
        m_err[d]    = 1'b0;
        m_cnt[d]    = 0;
        if (d == 0) qa.delete(); else qb.delete();
    endtask

    task automatic drive(int d, bit v, logic [2:0] code);
        @(posedge clk);
        #2;
        if (d == 0) begin
            ifa.in_valid = v;
            ifa.in       = code;
            if (v) qa.push_back(model(0, code));
        end else begin
            ifb.in_valid = v;
            ifb.in       = code;
            if (v) qb.push_back(model(1, code));
        end
    endtask

    task automatic flush(int d);
        drive(d, 1'b0, 3'b000);
        drive(d, 1'b0, 3'b000);
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_clr(int d);
        @(posedge clk);
        #2;
        if (d == 0) begin ifa.in_valid = 1'b0; clr_a = 1'b1; end
        else        begin ifb.in_valid = 1'b0; clr_b = 1'b1; end
        model_clear(d);
        @(posedge clk);
        #2;
        if (d == 0) clr_a = 1'b0; else clr_b = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!clr_a) begin
            checks++;
            aa = {ifa.idx, ifa.legal, ifa.fwd, ifa.bwd, ifa.hold, ifa.skip, ifa.err, ifa.err_cnt};
            if (ifa.out_valid) begin
                if (qa.size() == 0) begin
                    errors++;
                    $display("FAIL a_unexpected_out_valid got 1 required 0");
                end else begin
                    ea = qa.pop_front();
                    if (aa !== ea) begin
                        errors++;
                        $display("FAIL a_result got %h required %h", aa, ea);
                    end
                end
            end else if ({ifa.legal, ifa.fwd, ifa.bwd, ifa.hold, ifa.skip} !== 5'b0) begin
                errors++;
                $display("FAIL a_flags_idle got %b required 00000",
                         {ifa.legal, ifa.fwd, ifa.bwd, ifa.hold, ifa.skip});
            end
        end
    end

    always @(negedge clk) begin
        if (!clr_b) begin
            checks++;
            ab = {ifb.idx, ifb.legal, ifb.fwd, ifb.bwd, ifb.hold, ifb.skip, ifb.err, 6'b0, ifb.err_cnt};
            if (ifb.out_valid) begin
                if (qb.size() == 0) begin
                    errors++;
                    $display("FAIL b_unexpected_out_valid got 1 required 0");
                end else begin
                    eb = qb.pop_front();
                    if (ab !== eb) begin
                        errors++;
                        $display("FAIL b_result got %h required %h", ab, eb);
                    end
                end
            end else if ({ifb.legal, ifb.fwd, ifb.bwd, ifb.hold, ifb.skip} !== 5'b0) begin
                errors++;
                $display("FAIL b_flags_idle got %b required 00000",
                         {ifb.legal, ifb.fwd, ifb.bwd, ifb.hold, ifb.skip});
            end
        end
    end

    task automatic test_reset();
        ifa.in_valid = 1'b0; ifa.in = '0;
        ifb.in_valid = 1'b0; ifb.in = '0;
        #1;
        clr_a = 1'b1;
        clr_b = 1'b1;
        #1;
        checks++;
        if ({ifa.out_valid, ifa.idx, ifa.legal, ifa.err, ifa.err_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_state got %h required 0",
                     {ifa.out_valid, ifa.idx, ifa.legal, ifa.err, ifa.err_cnt});
        end
        @(posedge clk); #2;
        clr_a = 1'b0;
        clr_b = 1'b0;
        drive(0, 1'b1, 3'b010);
        drive(0, 1'b1, 3'b011);
        drive(0, 1'b0, 3'b000);
        checks++;
        if ({ifa.out_valid, ifa.err, ifa.err_cnt} !== {1'b1, 1'b1, 8'd1}) begin
            errors++;
            $display("FAIL pre_clr_state got %h required %h",
                     {ifa.out_valid, ifa.err, ifa.err_cnt}, {1'b1, 1'b1, 8'd1});
        end
        // Asynchronous clear mid-cycle; the 011 word is still in flight.
        clr_a = 1'b1;
        #1;
        checks++;
        if ({ifa.out_valid, ifa.idx, ifa.legal, ifa.fwd, ifa.bwd, ifa.hold,
             ifa.skip, ifa.err, ifa.err_cnt} !== '0) begin
            errors++;
            $display("FAIL async_clr got %h required 0",
                     {ifa.out_valid, ifa.idx, ifa.legal, ifa.fwd, ifa.bwd, ifa.hold,
                      ifa.skip, ifa.err, ifa.err_cnt});
        end
        model_clear(0);
        @(posedge clk); #2;
        clr_a = 1'b0;
        drive(0, 1'b0, 3'b000);
        checks++;
        if (ifa.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL discarded_word got out_valid=%b required 0", ifa.out_valid);
        end
        drive(0, 1'b1, 3'b011);
        @(posedge clk); #1;
        checks++;
        if (ifa.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early got out_valid=%b required 0", ifa.out_valid);
        end
        ifa.in_valid = 1'b0;
        flush(0);
        checks++;
        if (qa.size() != 0) begin
            errors++;
            $display("FAIL reset_drain got %0d pending required 0", qa.size());
        end
    endtask

    task automatic test_forward();
        logic [2:0] seq [7] = '{3'b000, 3'b001, 3'b011, 3'b111, 3'b110, 3'b100, 3'b000};
        pulse_clr(0);
        foreach (seq[i]) drive(0, 1'b1, seq[i]);
        flush(0);
        checks++;
        if ({qa.size() == 0, ifa.err, ifa.err_cnt} !== {1'b1, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL forward_end got pending=%0d err=%b cnt=%0d required 0 0 0",
                     qa.size(), ifa.err, ifa.err_cnt);
        end
    endtask

    task automatic test_back_hold();
        logic [2:0] seq [5] = '{3'b011, 3'b011, 3'b001, 3'b000, 3'b100};
        pulse_clr(0);
        foreach (seq[i]) drive(0, 1'b1, seq[i]);
        flush(0);
        checks++;
        if ({qa.size() == 0, ifa.err} !== 2'b10) begin
            errors++;
            $display("FAIL back_hold_end got pending=%0d err=%b required 0 0", qa.size(), ifa.err);
        end
    endtask

    task automatic test_illegal();
        pulse_clr(0);
        drive(0, 1'b1, 3'b001);
        drive(0, 1'b1, 3'b010);
        drive(0, 1'b1, 3'b011);
        flush(0);
        checks++;
        if ({qa.size() == 0, ifa.err, ifa.err_cnt} !== {1'b1, 1'b1, 8'd1}) begin
            errors++;
            $display("FAIL illegal_end got pending=%0d err=%b cnt=%0d required 0 1 1",
                     qa.size(), ifa.err, ifa.err_cnt);
        end
    endtask

    task automatic test_skip_gap();
        pulse_clr(0);
        drive(0, 1'b1, 3'b001);
        drive(0, 1'b1, 3'b111);
        flush(0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({ifa.out_valid, ifa.err, ifa.err_cnt} !== {1'b0, 1'b1, 8'd1}) begin
                errors++;
                $display("FAIL skip_gap got %h required %h",
                         {ifa.out_valid, ifa.err, ifa.err_cnt}, {1'b0, 1'b1, 8'd1});
            end
        end
        checks++;
        if (qa.size() != 0) begin
            errors++;
            $display("FAIL skip_drain got %0d pending required 0", qa.size());
        end
    endtask

    task automatic test_saturation();
        logic [2:0] seq [5] = '{3'b010, 3'b101, 3'b010, 3'b101, 3'b010};
        pulse_clr(1);
        foreach (seq[i]) drive(1, 1'b1, seq[i]);
        flush(1);
        checks++;
        if ({ifb.err, ifb.err_cnt} !== 3'b111) begin
            errors++;
            $display("FAIL sat_end got err=%b cnt=%0d required 1 3", ifb.err, ifb.err_cnt);
        end
        @(posedge clk); #2;
        clr_b = 1'b1;
        #1;
        checks++;
        if ({ifb.err, ifb.err_cnt} !== 3'b000) begin
            errors++;
            $display("FAIL sat_clr got err=%b cnt=%0d required 0 0", ifb.err, ifb.err_cnt);
        end
        model_clear(1);
        @(posedge clk); #2;
        clr_b = 1'b0;
        drive(1, 1'b1, 3'b011);
        flush(1);
        checks++;
        if (qb.size() != 0) begin
            errors++;
            $display("FAIL sat_drain got %0d pending required 0", qb.size());
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_back_hold();
        test_illegal();
        test_skip_gap();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/johnson_dec.md
Name: johnson_dec

Overview:
- Decoder and checker for the Johnson counter code. It is the receiving end of an n-bit Johnson counter bus.
- Converts each sampled Johnson code word to its binary state index and classifies the step from the previous legal word (forward, backward, hold, skip).
- Flags illegal code words and counts errors.
- Typical use: monitoring a Johnson counter that crosses a block boundary, or recovering a position count from a Johnson-coded source.

Parameters:
- n, 8, Johnson code width, must be >= 2. The code has 2n legal states.
- cw, 8, width of the saturating error counter, >= 1.
- Derived (localparam): w = $clog2(2n), the index width.

Ports:
- clk  input  1  clock, rising edge.
- clr  input  1  asynchronous reset ("clear"), active high.
- in_valid  input  1  sample qualifier; `in` is captured on rising clk while high.
- in  input  n  Johnson code word.
- out_valid  output  1  one-cycle pulse; result flags below are valid.
- idx  output  w  decoded state index, 0..2n-1.
- legal  output  1  sampled word was a legal Johnson code.
- fwd  output  1  idx = prev+1 mod 2n.
- bwd  output  1  idx = prev-1 mod 2n.
- hold  output  1  idx = prev.
- skip  output  1  legal word, but not prev, prev+1 or prev-1.
- err  output  1  sticky: an illegal word or a skip has occurred since clr.
- err_cnt  output  cw  number of error events, saturating.

Behaviour:
- Reset: clr asynchronous, active-high, clock clk.
  - While clr is high, all outputs are 0, including idx, err and err_cnt.
  - Internal prev = 0 and primed = 0.
  - clr mid-stream discards any word in flight; no out_valid is issued for it.
- Legal codes:
  - Low-thermometer: the m lowest bits set, m = 0..n, decodes to idx = m.
  - High-thermometer: the m highest bits set, m = 1..n-1, decodes to idx = 2n-m.
  - Example, n=3: 000=0, 001=1, 011=2, 111=3, 110=4, 100=5.
  - Every other pattern is illegal.
- Latency:
  - A word captured at edge k (in_valid=1) produces out_valid=1 at edge k+1, with all flags registered.
  - Decode and classification happen in the cycle between the two edges.
  - Throughput is one word per clock; back-to-back in_valid is allowed.
- Flags are valid only while out_valid=1 and are 0 otherwise. Exactly one of fwd/bwd/hold/skip may be 1.
- Illegal word:
  - legal=0, all four step flags 0.
  - idx keeps the last legal index (0 if none since clr).
  - prev and primed are unchanged.
  - Error event.
- First legal word after clr (primed=0):
  - legal=1, idx=decoded value, all step flags 0.
  - prev <= idx, primed <= 1.
  - Not an error.
- Subsequent legal words:
  - Exactly one of fwd/bwd/hold/skip is set; prev <= idx.
  - Wrap-around: 2n-1 -> 0 is fwd, 0 -> 2n-1 is bwd.
  - skip is an error event; fwd, bwd and hold are not.
  - For n=2, idx is 0..3; prev+2 mod 4 is skip.
- Error events:
  - err <= 1 and stays 1 until clr.
  - err_cnt increments by 1 per event and saturates at 2^cw-1 without wrapping.
  - At most one event per word.
- in_valid=0: no capture, no state change, out_valid=0 on the next cycle.
- Inputs are assumed synchronous to clk; synchronizing an asynchronous source is the integrator's job.

Test Plan (n=3, cw=8 unless stated):
- Reset: assert clr mid-cycle -> all outputs 0 immediately, without waiting for clk; after release, first out_valid appears only one cycle after an in_valid.
- Forward sequence: feed 000,001,011,111,110,100,000 back-to-back -> idx 0,1,2,3,4,5,0 one cycle later; first word has no step flag, the rest have fwd=1 (including 5->0); err=0, err_cnt=0.
- Backward and hold: feed 011,011,001,000,100 -> idx 2,2,1,0,5; flags none, hold, bwd, bwd, bwd (0->5 wrap); err=0.
- Illegal word: feed 001,010,011 -> second result legal=0 with idx=1; third result fwd=1 (prev unchanged by the illegal word); err=1, err_cnt=1.
- Skip: feed 001,111 -> second result skip=1, idx=3; err_cnt=1. Then gap in_valid=0 for 3 cycles -> out_valid=0 and counters stable.
- Saturation (cw=2): feed 5 illegal words (010,101,010,101,010) -> err_cnt 1,2,3,3,3; err=1; then clr -> err=0, err_cnt=0, next legal word has no step flag.
